// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcodes, FSM states and a small
// decode helper used by both the top level and its clients.
package alu_pkg;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_AND   = 4'b0010;
  localparam logic [3:0] ALU_NOR   = 4'b0011;
  localparam logic [3:0] ALU_OR    = 4'b0100;
  localparam logic [3:0] ALU_SLT   = 4'b0101;
  localparam logic [3:0] ALU_BEQ   = 4'b0110;
  localparam logic [3:0] ALU_BNE   = 4'b0111;
  localparam logic [3:0] ALU_SLTU  = 4'b1000;
  localparam logic [3:0] ALU_XOR   = 4'b1001;
  localparam logic [3:0] ALU_MULT  = 4'b1010;
  localparam logic [3:0] ALU_MULTU = 4'b1011;
  localparam logic [3:0] ALU_DIV   = 4'b1100;
  localparam logic [3:0] ALU_DIVU  = 4'b1101;
  localparam logic [3:0] ALU_SLL   = 4'b1110;
  localparam logic [3:0] ALU_BGEZ  = 4'b1111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2
  } state_t;

  // True for the opcodes handled by the iterative multiply/divide engine
  function automatic logic is_muldiv(input logic [3:0] op);
    return (op == ALU_MULT) || (op == ALU_MULTU) ||
           (op == ALU_DIV)  || (op == ALU_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_seq.sv
// Iterative multiply/divide engine: one shift-add (multiply) or restoring
// subtract (divide) step per cycle on operand magnitudes, with the sign
// fix-up folded into the final step. done is high during the last step and
// hi/lo then carry the finished, sign-corrected result for the caller to latch.
module muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             signed_op,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic [CW-1:0]    count;
  logic             div_mode;
  logic             neg_q;
  logic             neg_r;
  logic             div_zero;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic [WIDTH-1:0] opnd;

  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] next_hi;
  logic [WIDTH-1:0] next_lo;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_fix;

  assign a_neg = signed_op && a[WIDTH-1];
  assign b_neg = signed_op && b[WIDTH-1];
  assign a_mag = a_neg ? -a : a;
  assign b_mag = b_neg ? -b : b;
  assign done  = (count == CW'(1));

  // One iteration step plus the sign/divide-by-zero fix-up of its result
  always_comb begin
    sum    = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
    rem_sh = {acc_hi, acc_lo[WIDTH-1]};
    diff   = rem_sh - {1'b0, opnd};
    if (div_mode) begin
      if (!diff[WIDTH]) begin
        next_hi = diff[WIDTH-1:0];
        next_lo = {acc_lo[WIDTH-2:0], 1'b1};
      end else begin
        next_hi = rem_sh[WIDTH-1:0];
        next_lo = {acc_lo[WIDTH-2:0], 1'b0};
      end
    end else begin
      next_hi = sum[WIDTH:1];
      next_lo = {sum[0], acc_lo[WIDTH-1:1]};
    end
    prod     = {next_hi, next_lo};
    prod_fix = neg_q ? -prod : prod;
    if (div_mode) begin
      hi = neg_r ? -next_hi : next_hi;
      lo = div_zero ? {WIDTH{1'b1}} : (neg_q ? -next_lo : next_lo);
    end else begin
      hi = prod_fix[2*WIDTH-1:WIDTH];
      lo = prod_fix[WIDTH-1:0];
    end
  end

  // Load magnitudes on start, then iterate until the step counter runs out
  always_ff @(posedge clk) begin
    if (reset) begin
      count    <= '0;
      div_mode <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      opnd     <= '0;
    end else if (start) begin
      count    <= CW'(WIDTH);
      div_mode <= is_div;
      neg_q    <= a_neg ^ b_neg;
      neg_r    <= a_neg;
      div_zero <= (b == '0);
      acc_hi   <= '0;
      acc_lo   <= a_mag;
      opnd     <= b_mag;
    end else if (count != '0) begin
      count  <= count - CW'(1);
      acc_hi <= next_hi;
      acc_lo <= next_lo;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Registered EX-stage ALU. Single-cycle operations complete one cycle after
// acceptance; multiply/divide run in muldiv_seq while in_ready is held low.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] entr1,
  input  logic [WIDTH-1:0] entr2,
  output logic             out_valid,
  output logic [WIDTH-1:0] alu_result,
  output logic             zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  state_t           state;
  logic             accept;
  logic             md_start;
  logic             md_signed;
  logic             md_is_div;
  logic             md_done;
  logic [WIDTH-1:0] md_hi;
  logic [WIDTH-1:0] md_lo;
  logic [WIDTH-1:0] op_result;
  logic             op_zero;
  logic             is_branch;
  logic             branch_cond;

  assign in_ready  = (state == S_IDLE) && !reset;
  assign accept    = in_valid && in_ready;
  assign md_start  = accept && is_muldiv(alu_ctrl);
  assign md_signed = (alu_ctrl == ALU_MULT) || (alu_ctrl == ALU_DIV);
  assign md_is_div = (alu_ctrl == ALU_DIV) || (alu_ctrl == ALU_DIVU);

  muldiv_seq #(.WIDTH(WIDTH)) u_muldiv (
    .clk      (clk),
    .reset    (reset),
    .start    (md_start),
    .signed_op(md_signed),
    .is_div   (md_is_div),
    .a        (entr1),
    .b        (entr2),
    .done     (md_done),
    .hi       (md_hi),
    .lo       (md_lo)
  );

  // Single-cycle datapath; branches report their condition on zero instead
  always_comb begin
    op_result   = '0;
    is_branch   = 1'b0;
    branch_cond = 1'b0;
    case (alu_ctrl)
      ALU_ADD:  op_result = entr1 + entr2;
      ALU_SUB:  op_result = entr1 - entr2;
      ALU_AND:  op_result = entr1 & entr2;
      ALU_NOR:  op_result = ~(entr1 | entr2);
      ALU_OR:   op_result = entr1 | entr2;
      ALU_XOR:  op_result = entr1 ^ entr2;
      ALU_SLT:  op_result = {{(WIDTH-1){1'b0}}, ($signed(entr1) < $signed(entr2))};
      ALU_SLTU: op_result = {{(WIDTH-1){1'b0}}, (entr1 < entr2)};
      ALU_SLL:  op_result = entr1 << entr2[SHW-1:0];
      ALU_BEQ:  begin is_branch = 1'b1; branch_cond = (entr1 == entr2); end
      ALU_BNE:  begin is_branch = 1'b1; branch_cond = (entr1 != entr2); end
      ALU_BGEZ: begin is_branch = 1'b1; branch_cond = ($signed(entr1) >= $signed(entr2)); end
      default:  op_result = '0;
    endcase
    op_zero = is_branch ? branch_cond : (op_result == '0);
  end

  // Handshake FSM with registered result, flag, HI/LO and completion pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      out_valid  <= 1'b0;
      alu_result <= '0;
      zero       <= 1'b0;
      hi         <= '0;
      lo         <= '0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (is_muldiv(alu_ctrl)) begin
              state <= md_is_div ? S_DIV : S_MUL;
            end else begin
              out_valid  <= 1'b1;
              alu_result <= op_result;
              zero       <= op_zero;
            end
          end
        end
        S_MUL, S_DIV: begin
          if (md_done) begin
            state      <= S_IDLE;
            out_valid  <= 1'b1;
            hi         <= md_hi;
            lo         <= md_lo;
            alu_result <= md_lo;
            zero       <= (md_lo == '0);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
